// File: rtl/dircc_processing_mem_msg_reader.sv
// Avalon-MM read master on the 16-bit s2 port of the processing memory: takes a
// (start address, length) command and streams those words out as one Avalon-ST packet.
module dircc_processing_mem_msg_reader #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 8,
    parameter int MEM_WORDS  = 20480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [1:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_sop,
    output logic              src_eop,
    output logic              done,
    output logic [1:0]        dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never waits on ready, and payload stays stable while valid is held.

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [LEN_W-1:0]  out_idx_q, out_idx_d;
    logic              done_q, done_d;
    logic              inflight_q;

    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic issue, push, pop, accept, last_word;
    logic [CNT_W-1:0] reserved;

    // A read reserves its FIFO slot at issue time, so the capture a cycle later always fits.
    assign reserved  = count_q + CNT_W'(inflight_q);
    assign issue     = (state_q == S_FETCH) && (reserved < CNT_W'(FIFO_DEPTH));
    assign push      = inflight_q;
    assign pop       = src_valid && src_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign last_word = (out_idx_q == len_q - LEN_W'(1));

    assign cmd_ready      = (state_q == S_IDLE) && !reset;
    assign mem_address    = addr_q;
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 2'b11;
    assign mem_clken      = 1'b1;

    assign src_valid   = (count_q != '0);
    assign src_data    = src_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign src_sop     = src_valid && (out_idx_q == '0);
    assign src_eop     = src_valid && last_word;
    assign done        = done_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        remain_d  = remain_q;
        done_d    = 1'b0;
        out_idx_d = pop ? out_idx_q + LEN_W'(1) : out_idx_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d    = cmd_addr;
                    len_d     = cmd_len;
                    remain_d  = cmd_len;
                    out_idx_d = '0;
                    if (cmd_len == '0) done_d = 1'b1;
                    else               state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    addr_d   = (addr_q == ADDR_W'(MEM_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The eop pop is necessarily the last word: nothing is left in the FIFO or in flight.
                if (pop && last_word) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            remain_q   <= '0;
            out_idx_q  <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            remain_q   <= remain_d;
            out_idx_q  <= out_idx_d;
            done_q     <= done_d;
            inflight_q <= issue;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= mem_readdata;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));
        end
    end

endmodule
